// File: rtl/rxfp_pkg.sv
// Shared types and constants for the bus-frame receive parser.
package rxfp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID_L,
    ST_LEN_H,
    ST_LEN_L,
    ST_SID,
    ST_RW,
    ST_DATA,
    ST_CRC_H,
    ST_CRC_L,
    ST_SKIP
  } rxfp_state_e;

  localparam logic [15:0] CRC_POLY     = 16'hA001;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [1:0]  RW_READ      = 2'b11;
  localparam int unsigned HDR_OVERHEAD = 4;
  localparam int unsigned BYTE_W       = 8;

endpackage

// File: rtl/rx_frame_parser_if.sv
// Byte-receiver input and command/error outputs of the frame parser.
interface rx_frame_parser_if #(
  parameter int unsigned DATA_BYTES = 4
);
  localparam int unsigned SEN_W = 8 + 8 * DATA_BYTES;

  logic             rx_flag;
  logic [7:0]       rx_data;
  logic [7:0]       ret_cmd;
  logic             ret_cmd_flg;
  logic [SEN_W-1:0] sen_cmd;
  logic             sen_cmd_flag;
  logic             err_crc;
  logic             err_len;
  logic             err_timeout;

  // Byte receiver / command consumers side
  modport master (
    output rx_flag, rx_data,
    input  ret_cmd, ret_cmd_flg, sen_cmd, sen_cmd_flag,
    input  err_crc, err_len, err_timeout
  );

  // Parser side
  modport slave (
    input  rx_flag, rx_data,
    output ret_cmd, ret_cmd_flg, sen_cmd, sen_cmd_flag,
    output err_crc, err_len, err_timeout
  );

endinterface

// File: rtl/crc16_byte.sv
// One-byte CRC-16/MODBUS update (reflected), fully combinational.
module crc16_byte
  import rxfp_pkg::*;
(
  input  logic [15:0] crc_in_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_out_c_o
);

  logic [15:0] crc;

  // Eight unrolled shift/XOR steps, LSB first
  always_comb begin
    crc = crc_in_i ^ {8'h00, byte_i};
    for (int unsigned b = 0; b < 8; b++) begin
      crc = crc[0] ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
    end
    crc_out_c_o = crc;
  end

endmodule

// File: rtl/rx_frame_parser.sv
// Addressed bus-frame parser: header decode, foreign-frame skip, CRC-16 check,
// inter-byte timeout, and read-reply / sensor-write command generation.
module rx_frame_parser
  import rxfp_pkg::*;
#(
  parameter logic [15:0]  NODE_ID     = 16'h0001,
  parameter int unsigned  DATA_BYTES  = 4,
  parameter int unsigned  TIMEOUT_CYC = 50000
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  rx_frame_parser_if.slave bus
);

  localparam int unsigned PAY_W    = BYTE_W * DATA_BYTES;
  localparam int unsigned SEN_W    = BYTE_W + PAY_W;
  localparam int unsigned IDX_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned TMO_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int unsigned LEN_WR   = HDR_OVERHEAD + DATA_BYTES;
  localparam int unsigned LEN_RD   = HDR_OVERHEAD;

  rxfp_state_e      state_q,   state_d;
  logic [15:0]      crc_q,     crc_d;
  logic [15:0]      id_q,      id_d;
  logic [15:0]      len_q,     len_d;
  logic [7:0]       sid_q,     sid_d;
  logic             is_read_q, is_read_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [PAY_W-1:0] payload_q, payload_d;
  logic [15:0]      skip_q,    skip_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic [7:0]       crc_h_q,   crc_h_d;

  logic [7:0]       ret_cmd_q, ret_cmd_d;
  logic             ret_flg_q, ret_flg_d;
  logic [SEN_W-1:0] sen_cmd_q, sen_cmd_d;
  logic             sen_flg_q, sen_flg_d;
  logic             err_crc_q, err_crc_d;
  logic             err_len_q, err_len_d;
  logic             err_tmo_q, err_tmo_d;

  logic [15:0]      crc_seed;
  logic [15:0]      crc_next;
  logic [15:0]      len_rx;
  logic             rw_read;
  logic [15:0]      len_expect;

  // First byte of every frame folds into a freshly seeded CRC
  assign crc_seed   = (state_q == ST_IDLE) ? CRC_INIT : crc_q;
  assign len_rx     = {len_q[15:8], bus.rx_data};
  assign rw_read    = (bus.rx_data[1:0] == RW_READ);
  assign len_expect = rw_read ? 16'(LEN_RD) : 16'(LEN_WR);

  crc16_byte u_crc (
    .crc_in_i    (crc_seed),
    .byte_i      (bus.rx_data),
    .crc_out_c_o (crc_next)
  );

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    id_d      = id_q;
    len_d     = len_q;
    sid_d     = sid_q;
    is_read_d = is_read_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    skip_d    = skip_q;
    tmo_d     = tmo_q;
    crc_h_d   = crc_h_q;
    ret_cmd_d = ret_cmd_q;
    ret_flg_d = 1'b0;
    sen_cmd_d = sen_cmd_q;
    sen_flg_d = 1'b0;
    err_crc_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;

    if (bus.rx_flag) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          id_d    = {bus.rx_data, 8'h00};
          crc_d   = crc_next;
          state_d = ST_ID_L;
        end
        ST_ID_L: begin
          id_d    = {id_q[15:8], bus.rx_data};
          crc_d   = crc_next;
          state_d = ST_LEN_H;
        end
        ST_LEN_H: begin
          len_d   = {bus.rx_data, 8'h00};
          crc_d   = crc_next;
          state_d = ST_LEN_L;
        end
        ST_LEN_L: begin
          len_d = len_rx;
          crc_d = crc_next;
          if (id_q != NODE_ID) begin
            skip_d  = len_rx;
            state_d = (len_rx == 16'd0) ? ST_IDLE : ST_SKIP;
          end else begin
            state_d = ST_SID;
          end
        end
        ST_SID: begin
          sid_d   = bus.rx_data;
          crc_d   = crc_next;
          state_d = ST_RW;
        end
        ST_RW: begin
          crc_d     = crc_next;
          is_read_d = rw_read;
          idx_d     = '0;
          if (len_q != len_expect) begin
            // SID and RW already consumed two of the LEN bytes
            err_len_d = 1'b1;
            skip_d    = len_q - 16'd2;
            state_d   = (len_q <= 16'd2) ? ST_IDLE : ST_SKIP;
          end else begin
            state_d = rw_read ? ST_CRC_H : ST_DATA;
          end
        end
        ST_DATA: begin
          crc_d = crc_next;
          payload_d[{idx_q, 3'b000} +: BYTE_W] = bus.rx_data;
          if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
            state_d = ST_CRC_H;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        ST_CRC_H: begin
          crc_h_d = bus.rx_data;
          state_d = ST_CRC_L;
        end
        ST_CRC_L: begin
          state_d = ST_IDLE;
          if ({crc_h_q, bus.rx_data} == crc_q) begin
            if (is_read_q) begin
              ret_cmd_d = sid_q;
              ret_flg_d = 1'b1;
            end else begin
              sen_cmd_d = {sid_q, payload_q};
              sen_flg_d = 1'b1;
            end
          end else begin
            err_crc_d = 1'b1;
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 16'd1;
          if (skip_q == 16'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (TIMEOUT_CYC != 0) begin
      // A byte in the same cycle always wins over the abort
      if (tmo_q == TMO_W'(TMO_LAST)) begin
        tmo_d     = '0;
        err_tmo_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= ST_IDLE;
      crc_q     <= CRC_INIT;
      id_q      <= '0;
      len_q     <= '0;
      sid_q     <= '0;
      is_read_q <= 1'b0;
      idx_q     <= '0;
      payload_q <= '0;
      skip_q    <= '0;
      tmo_q     <= '0;
      crc_h_q   <= '0;
      ret_cmd_q <= '0;
      ret_flg_q <= 1'b0;
      sen_cmd_q <= '0;
      sen_flg_q <= 1'b0;
      err_crc_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      id_q      <= id_d;
      len_q     <= len_d;
      sid_q     <= sid_d;
      is_read_q <= is_read_d;
      idx_q     <= idx_d;
      payload_q <= payload_d;
      skip_q    <= skip_d;
      tmo_q     <= tmo_d;
      crc_h_q   <= crc_h_d;
      ret_cmd_q <= ret_cmd_d;
      ret_flg_q <= ret_flg_d;
      sen_cmd_q <= sen_cmd_d;
      sen_flg_q <= sen_flg_d;
      err_crc_q <= err_crc_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign bus.ret_cmd      = ret_cmd_q;
  assign bus.ret_cmd_flg  = ret_flg_q;
  assign bus.sen_cmd      = sen_cmd_q;
  assign bus.sen_cmd_flag = sen_flg_q;
  assign bus.err_crc      = err_crc_q;
  assign bus.err_len      = err_len_q;
  assign bus.err_timeout  = err_tmo_q;

endmodule

// File: doc/rx_frame_parser.md
# rx_frame_parser

Parametrised bus-frame receive parser between the byte receiver and the command consumers (bus reply generator, sensor command block). It decodes addressed frames of configurable payload width and verifies a CRC-16 trailer. It also skips frames addressed to other nodes and aborts stalled frames on an inter-byte timeout. Only CRC-valid frames for this node generate a read-reply request or a sensor write command.

## Interface
- NODE_ID, 16'h0001, this node's bus address
- DATA_BYTES, 4, write payload bytes per frame, legal 1..16
- TIMEOUT_CYC, 50000, idle cycles between bytes before abort; 0 disables timeout
- sys_clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-low
- rx_flag  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- ret_cmd  out  8  sensor ID to read back
- ret_cmd_flg  out  1  one-cycle pulse, ret_cmd valid
- sen_cmd  out  8+8*DATA_BYTES  {sensor ID, payload}; first payload byte in bits [7:0]
- sen_cmd_flag  out  1  one-cycle pulse, sen_cmd valid
- err_crc  out  1  one-cycle pulse, CRC mismatch on own frame
- err_len  out  1  one-cycle pulse, LEN inconsistent with RW
- err_timeout  out  1  one-cycle pulse, frame aborted by timeout

## Operation
- Frame order: ID_H, ID_L, LEN_H, LEN_L, SID, RW, DATA×N, CRC_H, CRC_L.
- LEN is the count of bytes following LEN_L, CRC included.
- RW[1:0]==2'b11 means read, with N=0. Any other value means write, with N=DATA_BYTES.
- CRC is CRC-16/MODBUS: reflected poly 0xA001, init 0xFFFF, no final XOR. It covers ID_H through the last DATA byte, and the received value is {CRC_H,CRC_L}.
- States: IDLE, ID_L, LEN_H, LEN_L, SID, RW, DATA, CRC_H, CRC_L, SKIP. A state advances only on rx_flag.
- IDLE: each byte starts a new frame (the byte is ID_H), and CRC is reseeded to 0xFFFF before folding it in.
- LEN_L: if ID≠NODE_ID and LEN==0, go to IDLE. If ID≠NODE_ID and LEN>0, go to SKIP with skip count=LEN. If ID matches, go to SID.
- RW: expected LEN is 4+N. On mismatch, pulse err_len; go to SKIP with count LEN−2 (or IDLE if LEN≤2). On match, go to DATA (write) or CRC_H (read).
- DATA: byte index counts 0..DATA_BYTES−1, then CRC_H.
- SKIP: the count decrements per byte. The byte that takes the count from 1 to 0 returns the parser to IDLE.
- CRC_L on a match: read frames pulse ret_cmd_flg with ret_cmd=SID; write frames pulse sen_cmd_flag with sen_cmd={SID,payload}. On a mismatch, pulse err_crc and issue no command. Either way, return to IDLE.
- Timeout: the counter clears on every rx_flag and while in IDLE. If it reaches TIMEOUT_CYC in any other state, return to IDLE and pulse err_timeout. If rx_flag occurs in that same cycle, the byte wins and no timeout occurs.
- ret_cmd and sen_cmd hold their last issued value until the next command. Partial payloads never reach sen_cmd.

## Timing
- Reset values: all outputs 0, state IDLE, CRC 0xFFFF, all counters 0.
- A reset in mid-frame discards the frame, and no pulse is issued.
- All outputs are registered.
- Command/error pulse: the rx_flag carrying CRC_L (or RW, for err_len) is sampled at edge k; the pulse is high in cycle k+1 for exactly one cycle.
- err_timeout is high for the single cycle after the aborting edge.
- Back-to-back rx_flag on every cycle must be accepted without loss. The CRC byte update is combinational within one cycle.
- A new ID_H may arrive in the cycle a command pulse is high.

## Structure
- Shared package rxfp_pkg holds:
  - the state enum;
  - CRC_POLY=16'hA001 and CRC_INIT=16'hFFFF;
  - the RW_READ mask 2'b11;
  - the header-overhead constant 4.
- Sub-module crc16_byte: combinational, (crc_in[15:0], byte[7:0]) -> crc_out[15:0], eight unrolled shift/XOR steps.
- Skip counter is 16 bits wide; the timeout counter width is $clog2(TIMEOUT_CYC+1).

## Test plan
- NODE_ID=0x0001, frame 00 01 00 04 07 03 + correct CRC -> ret_cmd=0x07, ret_cmd_flg pulse at k+1, no other pulses.
- Write frame 00 01 00 08 05 00 11 22 33 44 + correct CRC -> sen_cmd=0x05_44332211, sen_cmd_flag one cycle.
- Same write frame with CRC_L XOR 0x01 -> err_crc pulse, sen_cmd unchanged, next valid frame is still accepted.
- Foreign frame 00 02 00 03 AA BB CC, then an own read frame -> the three bytes are skipped with no pulses, and the read is decoded correctly.
- Own read frame with LEN=0x0006 -> err_len at RW, four bytes skipped, then IDLE.
- TIMEOUT_CYC=10: send 00 01 00 then idle 10 cycles -> err_timeout pulse, next byte is treated as ID_H. Repeat with rx_flag landing exactly on cycle 10 -> no timeout.
